// File: rtl/parking_gate_ctrl.sv
// Parking-gate controller: password entry, gate sequencing, inactivity timeout,
// brute-force lockout and occupancy counting in one registered FSM.
`timescale 1ns/1ps
module parking_gate_ctrl #(
   parameter int                    PASS_LEN  = 4,
   parameter logic [2*PASS_LEN-1:0] PASSWORD  = 8'b11_10_01_00,
   parameter int                    TIMEOUT_S = 20,
   parameter int                    MAX_TRIES = 3,
   parameter int                    LOCK_S    = 30,
   parameter int                    ERR_S     = 2,
   parameter int                    CAPACITY  = 16,
   parameter int                    CNT_W     = 8
) (
   input  logic             CLK_FPGA,
   input  logic             RST_N,
   input  logic             tick_1hz,
   input  logic [1:0]       code,
   input  logic             code_valid,
   input  logic             Se,
   input  logic             Si,
   input  logic             exit_pulse,
   output logic             cancela,
   output logic             digite_senha,
   output logic             erro,
   output logic             bloqueado,
   output logic             cheio,
   output logic [CNT_W-1:0] ocupacao,
   output logic [2:0]       estado
);

   localparam int TMAX_A = (TIMEOUT_S > LOCK_S) ? TIMEOUT_S : LOCK_S;
   localparam int TMAX   = (TMAX_A > ERR_S) ? TMAX_A : ERR_S;
   localparam int TW     = $clog2(TMAX + 1);
   localparam int IW     = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
   localparam int RW     = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SENHA    = 3'd1,
      ERRO     = 3'd2,
      BLOQUEIO = 3'd3,
      ABERTO   = 3'd4,
      PASSANDO = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d, timer_inc;
   logic [IW-1:0]    idx_q, idx_d;
   logic             mis_q, mis_d, mis_now, last_digit;
   logic [RW-1:0]    tries_q, tries_d, tries_inc;
   logic [CNT_W-1:0] ocup_q, ocup_d;
   logic             full, car_in;
   logic [1:0]       digit;

   assign timer_inc  = timer_q + 1'b1;
   assign tries_inc  = tries_q + 1'b1;
   assign digit      = PASSWORD[2*idx_q +: 2];
   assign mis_now    = mis_q | (code != digit);
   assign last_digit = (idx_q == IW'(PASS_LEN - 1));
   assign full       = (ocup_q == CNT_W'(CAPACITY));

   always_ff @(posedge CLK_FPGA or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         tries_q <= '0;
         ocup_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         tries_q <= tries_d;
         ocup_q  <= ocup_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      tries_d = tries_q;
      car_in  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Se && !full) begin
               state_d = SENHA;
               idx_d   = '0;
               mis_d   = 1'b0;
            end
         end
         SENHA: begin
            // A key press restarts the inactivity timer even on a tick cycle.
            if (!Se) begin
               state_d = IDLE;
            end else if (code_valid) begin
               timer_d = '0;
               if (last_digit) begin
                  if (!mis_now) begin
                     state_d = ABERTO;
                     tries_d = '0;
                  end else begin
                     tries_d = tries_inc;
                     state_d = (tries_inc == RW'(MAX_TRIES)) ? BLOQUEIO : ERRO;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
                  mis_d = mis_now;
               end
            end else if (tick_1hz) begin
               if (timer_inc == TW'(TIMEOUT_S)) state_d = IDLE;
               else                             timer_d = timer_inc;
            end
         end
         ERRO: begin
            if (tick_1hz) begin
               if (timer_inc == TW'(ERR_S)) begin
                  state_d = Se ? SENHA : IDLE;
                  idx_d   = '0;
                  mis_d   = 1'b0;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         BLOQUEIO: begin
            if (tick_1hz) begin
               if (timer_inc == TW'(LOCK_S)) begin
                  state_d = IDLE;
                  tries_d = '0;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         ABERTO: begin
            if (Si) begin
               state_d = PASSANDO;
            end else if (tick_1hz) begin
               if (timer_inc == TW'(TIMEOUT_S)) state_d = IDLE;
               else                             timer_d = timer_inc;
            end
         end
         PASSANDO: begin
            // Entered with Si high, so Si low here is the falling edge.
            if (!Si) begin
               state_d = IDLE;
               car_in  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) timer_d = '0;

      ocup_d = ocup_q;
      if (car_in && !exit_pulse && !full)
         ocup_d = ocup_q + 1'b1;
      else if (exit_pulse && !car_in && (ocup_q != '0))
         ocup_d = ocup_q - 1'b1;
   end

   always_comb begin
      estado       = state_q;
      cancela      = (state_q == ABERTO) || (state_q == PASSANDO);
      digite_senha = (state_q == SENHA);
      erro         = (state_q == ERRO) || (state_q == BLOQUEIO);
      bloqueado    = (state_q == BLOQUEIO);
      cheio        = full;
      ocupacao     = ocup_q;
   end

endmodule
